// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle RV32I core: opcode constants,
// ALU/branch/writeback enums and small funct3 decode helpers.
package cpu_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE,
        BR_EQ,
        BR_NE,
        BR_LT,
        BR_GE,
        BR_LTU,
        BR_GEU
    } br_type_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_PC4,
        WB_LOAD
    } wb_sel_e;

    // alt is funct7[5]; only SUB and SRA/SRAI look at it.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic br_type_e br_decode(input logic [2:0] f3);
        br_type_e bt;
        case (f3)
            3'b000:  bt = BR_EQ;
            3'b001:  bt = BR_NE;
            3'b100:  bt = BR_LT;
            3'b101:  bt = BR_GE;
            3'b110:  bt = BR_LTU;
            3'b111:  bt = BR_GEU;
            default: bt = BR_NONE;
        endcase
        return bt;
    endfunction

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational integer ALU; shifts use b[4:0], compares come back as 0/1.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] y_o
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;

    assign shamt = b_i[4:0];
    assign lt_s  = $signed(a_i) < $signed(b_i);
    assign lt_u  = a_i < b_i;

    always_comb begin
        y_o = '0;
        case (alu_op_e'(op_i))
            ALU_ADD:    y_o = a_i + b_i;
            ALU_SUB:    y_o = a_i - b_i;
            ALU_SLL:    y_o = a_i << shamt;
            ALU_SLT:    y_o = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU:   y_o = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:    y_o = a_i ^ b_i;
            ALU_SRL:    y_o = a_i >> shamt;
            ALU_SRA:    y_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:     y_o = a_i | b_i;
            ALU_AND:    y_o = a_i & b_i;
            ALU_PASS_B: y_o = b_i;
            default:    y_o = '0;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// Single-cycle RV32I core with external synchronous instruction memory
// (addressed with next PC) and external data memory.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    output logic [XLEN-1:0] imemaddr,
    input  logic [XLEN-1:0] imemdataout,
    output logic            imemclk,
    output logic [XLEN-1:0] dmemaddr,
    input  logic [XLEN-1:0] dmemdataout,
    output logic [XLEN-1:0] dmemdatain,
    output logic            dmemrdclk,
    output logic            dmemwrclk,
    output logic [2:0]      dmemop,
    output logic            dmemwe,
    output logic [XLEN-1:0] dbgdata
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] rf_q [0:31];

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] pc_plus4;

    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    alu_op_e         alu_op;
    logic [XLEN-1:0] alu_y;
    logic            rf_we;
    wb_sel_e         wb_sel;
    logic            store_en;
    br_type_e        br_type;
    logic            br_taken;
    logic            jump_en;
    logic [XLEN-1:0] jump_tgt;
    logic [XLEN-1:0] wb_data;

    assign opcode = imemdataout[6:0];
    assign rd     = imemdataout[11:7];
    assign funct3 = imemdataout[14:12];
    assign rs1    = imemdataout[19:15];
    assign rs2    = imemdataout[24:20];
    assign funct7 = imemdataout[31:25];

    assign imm_i = XLEN'($signed(imemdataout[31:20]));
    assign imm_s = XLEN'($signed({imemdataout[31:25], imemdataout[11:7]}));
    assign imm_b = XLEN'($signed({imemdataout[31], imemdataout[7], imemdataout[30:25],
                                  imemdataout[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({imemdataout[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({imemdataout[31], imemdataout[19:12], imemdataout[20],
                                  imemdataout[30:21], 1'b0}));

    assign rs1_val  = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? '0 : rf_q[rs2];
    assign pc_plus4 = pc_q + XLEN'(4);

    // Anything not recognised below falls through the defaults as a no-op.
    always_comb begin
        alu_a    = rs1_val;
        alu_b    = imm_i;
        alu_op   = ALU_ADD;
        rf_we    = 1'b0;
        wb_sel   = WB_ALU;
        store_en = 1'b0;
        br_type  = BR_NONE;
        jump_en  = 1'b0;
        jump_tgt = pc_q + imm_j;
        case (opcode)
            OPC_LUI: begin
                alu_b  = imm_u;
                alu_op = ALU_PASS_B;
                rf_we  = 1'b1;
            end
            OPC_AUIPC: begin
                alu_a = pc_q;
                alu_b = imm_u;
                rf_we = 1'b1;
            end
            OPC_JAL: begin
                rf_we   = 1'b1;
                wb_sel  = WB_PC4;
                jump_en = 1'b1;
            end
            OPC_JALR: begin
                rf_we    = 1'b1;
                wb_sel   = WB_PC4;
                jump_en  = 1'b1;
                jump_tgt = {alu_y[XLEN-1:1], 1'b0};
            end
            OPC_BRANCH: begin
                br_type = br_decode(funct3);
            end
            OPC_LOAD: begin
                rf_we  = load_f3_ok(funct3);
                wb_sel = WB_LOAD;
            end
            OPC_STORE: begin
                alu_b    = imm_s;
                store_en = store_f3_ok(funct3);
            end
            OPC_OPIMM: begin
                alu_op = alu_decode(funct3, (funct3 == 3'b101) && funct7[5]);
                rf_we  = 1'b1;
            end
            OPC_OP: begin
                alu_b  = rs2_val;
                alu_op = alu_decode(funct3, funct7[5]);
                rf_we  = (funct7 == 7'b0000000) ||
                         ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            default: begin
            end
        endcase
    end

    cpu_alu #(.XLEN(XLEN)) u_alu (
        .op_i (alu_op),
        .a_i  (alu_a),
        .b_i  (alu_b),
        .y_o  (alu_y)
    );

    always_comb begin
        br_taken = 1'b0;
        case (br_type)
            BR_EQ:   br_taken = rs1_val == rs2_val;
            BR_NE:   br_taken = rs1_val != rs2_val;
            BR_LT:   br_taken = $signed(rs1_val) <  $signed(rs2_val);
            BR_GE:   br_taken = $signed(rs1_val) >= $signed(rs2_val);
            BR_LTU:  br_taken = rs1_val <  rs2_val;
            BR_GEU:  br_taken = rs1_val >= rs2_val;
            default: br_taken = 1'b0;
        endcase
    end

    // Reset forces the fetch address so the memory is preloaded with RESET_PC.
    always_comb begin
        if (!reset) begin
            pc_d = RESET_PC;
        end else if (jump_en) begin
            pc_d = jump_tgt;
        end else if (br_taken) begin
            pc_d = pc_q + imm_b;
        end else begin
            pc_d = pc_plus4;
        end
    end

    always_comb begin
        case (wb_sel)
            WB_PC4:  wb_data = pc_plus4;
            WB_LOAD: wb_data = dmemdataout;
            default: wb_data = alu_y;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we && (rd != 5'd0)) begin
            rf_q[rd] <= wb_data;
        end
    end

    assign imemaddr   = pc_d;
    assign imemclk    = clock;
    assign dmemrdclk  = ~clock;
    assign dmemwrclk  = clock;
    assign dmemaddr   = alu_y;
    assign dmemdatain = rs2_val;
    assign dmemop     = funct3;
    assign dmemwe     = store_en & reset;
    assign dbgdata    = pc_q;

endmodule

// File: tb/tb_cpu_core.sv
// Directed program for cpu_core; register results are observed through
// stores on the data bus, and every cycle's PC and bus state is checked.
module tb_cpu_core;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imemaddr;
    logic [31:0] imemdataout;
    logic        imemclk;
    logic [31:0] dmemaddr;
    logic [31:0] dmemdataout;
    logic [31:0] dmemdatain;
    logic        dmemrdclk;
    logic        dmemwrclk;
    logic [2:0]  dmemop;
    logic        dmemwe;
    logic [31:0] dbgdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    cpu_core #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .imemaddr    (imemaddr),
        .imemdataout (imemdataout),
        .imemclk     (imemclk),
        .dmemaddr    (dmemaddr),
        .dmemdataout (dmemdataout),
        .dmemdatain  (dmemdatain),
        .dmemrdclk   (dmemrdclk),
        .dmemwrclk   (dmemwrclk),
        .dmemop      (dmemop),
        .dmemwe      (dmemwe),
        .dbgdata     (dbgdata)
    );

    logic [31:0] imem [0:63];
    logic [7:0]  dmem [0:255];

    always @(posedge imemclk) begin
        imemdataout <= imem[imemaddr[7:2]];
    end

    always @(posedge dmemrdclk) begin
        logic [7:0] a;
        a = dmemaddr[7:0];
        case (dmemop)
            3'b000:  dmemdataout <= {{24{dmem[a][7]}}, dmem[a]};
            3'b001:  dmemdataout <= {{16{dmem[a+8'd1][7]}}, dmem[a+8'd1], dmem[a]};
            3'b100:  dmemdataout <= {24'b0, dmem[a]};
            3'b101:  dmemdataout <= {16'b0, dmem[a+8'd1], dmem[a]};
            default: dmemdataout <= {dmem[a+8'd3], dmem[a+8'd2], dmem[a+8'd1], dmem[a]};
        endcase
    end

    always @(posedge dmemwrclk) begin
        logic [7:0] a;
        a = dmemaddr[7:0];
        if (dmemwe) begin
            dmem[a] <= dmemdatain[7:0];
            if (dmemop[1:0] != 2'b00) dmem[a+8'd1] <= dmemdatain[15:8];
            if (dmemop[1:0] == 2'b10) begin
                dmem[a+8'd2] <= dmemdatain[23:16];
                dmem[a+8'd3] <= dmemdatain[31:24];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h, want %08h", tag, got, exp);
        end
    endtask

    // Expected store for each PC of the program (hand-computed register values).
    task automatic exp_store(input logic [31:0] pc, output logic we,
                             output logic [31:0] addr, output logic [31:0] data);
        we   = 1'b1;
        addr = 32'h0;
        data = 32'h0;
        case (pc)
            32'h10:  begin addr = 32'd8;  data = 32'd5;        end
            32'h18:  begin addr = 32'd12; data = 32'd2;        end
            32'h1C:  begin addr = 32'd16; data = 32'd1;        end
            32'h28:  begin addr = 32'd20; data = 32'h34;       end
            32'h40:  begin addr = 32'd24; data = 32'hFFFFFF80; end
            32'h48:  begin addr = 32'd28; data = 32'h0;        end
            32'h54:  begin addr = 32'd32; data = 32'hF8000000; end
            32'h5C:  begin addr = 32'd36; data = 32'd1;        end
            32'h70:  begin addr = 32'd40; data = 32'h64;       end
            32'h78:  begin addr = 32'd44; data = 32'h1074;     end
            32'h88:  begin addr = 32'd48; data = 32'h7FFFFFCC; end
            default: we = 1'b0;
        endcase
    endtask

    logic [31:0] pc_seq [0:29] = '{
        32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C,
        32'h20, 32'h30, 32'h28, 32'h2C, 32'h40, 32'h44, 32'h48, 32'h4C,
        32'h50, 32'h54, 32'h58, 32'h5C, 32'h60, 32'h70, 32'h74, 32'h78,
        32'h7C, 32'h80, 32'h84, 32'h88, 32'h8C, 32'h8C
    };

    initial begin
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cur;

        for (int i = 0; i < 64; i++) imem[i] = 32'h00000013;
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
        dmem[0] = 8'h80;

        imem[6'h00] = 32'h00500093; // addi x1,x0,5
        imem[6'h01] = 32'hFFD00113; // addi x2,x0,-3
        imem[6'h02] = 32'h002081B3; // add  x3,x1,x2
        imem[6'h03] = 32'h0020B233; // sltu x4,x1,x2
        imem[6'h04] = 32'h00102423; // sw   x1,8(x0)
        imem[6'h05] = 32'h00000283; // lb   x5,0(x0)
        imem[6'h06] = 32'h00302623; // sw   x3,12(x0)
        imem[6'h07] = 32'h00402823; // sw   x4,16(x0)
        imem[6'h08] = 32'h00000863; // beq  x0,x0,+16
        imem[6'h0A] = 32'h00102A23; // sw   x1,20(x0)
        imem[6'h0B] = 32'h0140006F; // jal  x0,+20
        imem[6'h0C] = 32'hFF9FF0EF; // jal  x1,-8
        imem[6'h10] = 32'h00502C23; // sw   x5,24(x0)
        imem[6'h11] = 32'h00700013; // addi x0,x0,7
        imem[6'h12] = 32'h00002E23; // sw   x0,28(x0)
        imem[6'h13] = 32'h80000337; // lui  x6,0x80000
        imem[6'h14] = 32'h40435393; // srai x7,x6,4
        imem[6'h15] = 32'h02702023; // sw   x7,32(x0)
        imem[6'h16] = 32'h00132433; // slt  x8,x6,x1
        imem[6'h17] = 32'h02802223; // sw   x8,36(x0)
        imem[6'h18] = 32'h03D084E7; // jalr x9,0x3D(x1)
        imem[6'h1C] = 32'h02902423; // sw   x9,40(x0)
        imem[6'h1D] = 32'h00001517; // auipc x10,1
        imem[6'h1E] = 32'h02A02623; // sw   x10,44(x0)
        imem[6'h1F] = 32'h00000073; // ecall
        imem[6'h20] = 32'h00109463; // bne  x1,x1,+8
        imem[6'h21] = 32'h401305B3; // sub  x11,x6,x1
        imem[6'h22] = 32'h02B02823; // sw   x11,48(x0)
        imem[6'h23] = 32'h0000006F; // jal  x0,0

        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_imemaddr", imemaddr, 32'h0);
        check_eq("rst_dbgdata", dbgdata, 32'h0);
        check_eq("rst_dmemwe", {31'b0, dmemwe}, 32'h0);

        @(negedge clock);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 30; i++) begin
            cur = pc_seq[i];
            check_eq("pc", dbgdata, cur);
            exp_store(cur, we, addr, data);
            check_eq("dmemwe", {31'b0, dmemwe}, {31'b0, we});
            if (we) begin
                check_eq("st_addr", dmemaddr, addr);
                check_eq("st_data", dmemdatain, data);
                check_eq("st_op", {29'b0, dmemop}, 32'h2);
            end
            if (cur == 32'h14) begin
                check_eq("lb_addr", dmemaddr, 32'h0);
                check_eq("lb_op", {29'b0, dmemop}, 32'h0);
            end
            $display("cycle %0d pc=%08h we=%0b addr=%08h wdata=%08h op=%03b",
                     i, dbgdata, dmemwe, dmemaddr, dmemdatain, dmemop);
            @(posedge clock);
            #1;
        end

        #2;
        reset = 1'b0;
        #1;
        check_eq("midrst_dbgdata", dbgdata, 32'h0);
        check_eq("midrst_imemaddr", imemaddr, 32'h0);
        check_eq("midrst_dmemwe", {31'b0, dmemwe}, 32'h0);
        $display("mid-program reset pc=%08h imemaddr=%08h", dbgdata, imemaddr);

        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("restart_pc0", dbgdata, 32'h0);
        @(posedge clock);
        #1;
        check_eq("restart_pc4", dbgdata, 32'h4);
        $display("restart pc=%08h", dbgdata);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 SHALL provide parameter XLEN, default 32, meaning data, address and instruction width.
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning reset vector.
REQ-003 SHALL have port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; all state is reset while reset=0.
REQ-005 SHALL have port imemaddr, output, 32 bits: instruction fetch address.
REQ-006 SHALL have port imemdataout, input, 32 bits: instruction word from the synchronous instruction memory.
REQ-007 SHALL have port imemclk, output, 1 bit: instruction memory read clock.
REQ-008 SHALL have port dmemaddr, output, 32 bits: data byte address.
REQ-009 SHALL have port dmemdataout, input, 32 bits: load data returned by the data memory, already extended per dmemop.
REQ-010 SHALL have port dmemdatain, output, 32 bits: store data, aligned to bit 0.
REQ-011 SHALL have port dmemrdclk, output, 1 bit: data memory read clock.
REQ-012 SHALL have port dmemwrclk, output, 1 bit: data memory write clock.
REQ-013 SHALL have port dmemop, output, 3 bits: access type equal to funct3 (000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned).
REQ-014 SHALL have port dmemwe, output, 1 bit: store enable.
REQ-015 SHALL have port dbgdata, output, 32 bits: current PC.

Function
REQ-016 SHALL execute RV32I (LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM, OP) single-cycle, one instruction per clock.
REQ-017 SHALL treat FENCE, ECALL, EBREAK, SYSTEM and unknown opcodes as no-ops: no register or memory write, PC+4.
REQ-018 SHALL drive imemaddr = NextPC combinationally and imemclk = clock, so the memory captures the next instruction on the same edge that updates PC.
REQ-019 SHALL drive dmemrdclk = ~clock (load captured mid-cycle) and dmemwrclk = clock (store committed at cycle end).
REQ-020 SHALL compute dmemaddr = rs1 + sign-extended imm for loads and stores.
REQ-021 SHALL assert dmemwe only for stores, with dmemdatain = rs2 and dmemop = funct3.
REQ-022 SHALL produce NextPC as: PC+4 by default; PC+imm for JAL and taken branches; (rs1+imm) & ~1 for JALR.
REQ-023 SHALL write the link value PC+4 to rd for JAL and JALR.
REQ-024 SHALL write the register file on the rising clock edge; writes to x0 are discarded and x0 reads as 0.
REQ-025 SHALL apply the shift amount as operand[4:0] and implement SRA/SRAI as arithmetic shifts.
REQ-026 SHALL implement SLT and SLTU as signed and unsigned compares; all arithmetic wraps modulo 2^32.
REQ-027 SHALL NOT check alignment; misaligned addresses are passed to memory unchanged.

Reset
REQ-028 SHALL, while reset=0, hold PC=RESET_PC, force NextPC=RESET_PC, hold dmemwe=0 and clear x1..x31 to 0.
REQ-029 SHALL execute the instruction at RESET_PC in the first cycle after release; reset must span at least one clock edge so that it is preloaded.

Structure
REQ-030 SHALL keep the opcode constants, the ALU-op enum and the branch-type enum in the shared package cpu_pkg.
REQ-031 SHALL place the ALU in a single sub-module, cpu_alu; the register file, decoder and next-PC logic are inline.
REQ-032 SHALL keep the instruction and data memories external.

Verification
REQ-033 SHALL check: reset=0 across two edges -> imemaddr=0, dbgdata=0, dmemwe=0.
REQ-034 SHALL check: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2 -> x3=2; sltu x4,x1,x2 -> x4=1.
REQ-035 SHALL check: sw x1,8(x0) -> dmemwe=1, dmemaddr=8, dmemdatain=5, dmemop=010 for exactly one cycle.
REQ-036 SHALL check: lb x5,0(x0) with memory returning 0xFFFFFF80 -> x5=0xFFFFFF80 and dmemop=000.
REQ-037 SHALL check: beq x0,x0,+16 at PC 0x20 -> next dbgdata=0x30; jal x1,-8 at 0x30 -> PC 0x28, x1=0x34.
REQ-038 SHALL check: addi x0,x0,7 -> x0 still reads 0; reset asserted mid-program -> PC returns to 0 immediately.
